// File: rtl/microtile_pkg.sv
// -----------------------------------------------------------------------------
// microtile_pkg
// Shared types and helpers for the micro-tile scan monitor.
//   meas_state_t : measurement FSM states (IDLE, COUNT)
//   width_for()  : number of bits needed to hold values 0..max_val
// -----------------------------------------------------------------------------
package microtile_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } meas_state_t;

    // Smallest width that can represent max_val. Never returns less than one
    // bit, so a degenerate counter still gets a legal vector.
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/microtile_edge_counter.sv
// -----------------------------------------------------------------------------
// microtile_edge_counter
// Gated rising-edge counter used to measure activity on one bit of the
// selected tile bus. A start request opens a GATE-cycle window; at the end of
// the window the saturated count is published with a one-cycle valid pulse.
// An abort closes the window early and pulses err instead.
// Ports:
//   clk, rst      : system clock, asynchronous active-high reset
//   start         : open a window (ignored while one is already open)
//   abort         : close the open window without publishing a result
//   sample        : the bit being watched
//   busy          : a window is open
//   freq_count    : last completed count
//   freq_valid    : one-cycle pulse when freq_count updates
//   freq_err      : one-cycle pulse when a window is aborted
// -----------------------------------------------------------------------------
module microtile_edge_counter
    import microtile_pkg::*;
#(
    parameter int GATE = 64,
    parameter int CW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          sample,
    output logic          busy,
    output logic [CW-1:0] freq_count,
    output logic          freq_valid,
    output logic          freq_err
);

    localparam int GW = width_for(GATE);
    localparam logic [GW-1:0] GATE_LOAD  = GW'(GATE);
    localparam logic [GW-1:0] WIN_ONE    = GW'(1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_MAX    = '1;

    meas_state_t   state;
    meas_state_t   state_next;
    logic [GW-1:0] window;
    logic [CW-1:0] edges;
    logic [CW-1:0] edges_next;
    logic          prev;
    logic          load;
    logic          finish;
    logic          kill;

    // Next-state decode. An abort wins over a window that happens to expire
    // in the same cycle, so a disturbed measurement is never published.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        finish     = 1'b0;
        kill       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = COUNT;
                    load       = 1'b1;
                end
            end
            COUNT: begin
                if (abort) begin
                    state_next = IDLE;
                    kill       = 1'b1;
                end else if (window == WIN_ONE) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Count including the current sample; sticks at all-ones instead of
    // wrapping so a fast oscillator reads as "at least max", never as low.
    always_comb begin
        edges_next = edges;
        if (sample && !prev && (edges != CNT_MAX)) begin
            edges_next = edges + CNT_ONE;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Window, edge detector and result registers. The window is loaded with
    // GATE and the last sample is taken as it goes from 1 to 0, so exactly
    // GATE samples land in the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window     <= '0;
            edges      <= '0;
            prev       <= 1'b0;
            freq_count <= '0;
            freq_valid <= 1'b0;
            freq_err   <= 1'b0;
        end else begin
            freq_valid <= finish;
            freq_err   <= kill;
            if (load) begin
                window <= GATE_LOAD;
                edges  <= '0;
                prev   <= sample;
            end else if (state == COUNT) begin
                window <= window - WIN_ONE;
                edges  <= edges_next;
                prev   <= sample;
            end
            if (finish) begin
                freq_count <= edges_next;
            end
        end
    end

    assign busy = (state == COUNT);

endmodule

// File: rtl/microtile_scan_monitor.sv
// -----------------------------------------------------------------------------
// microtile_scan_monitor
// Brings NCH asynchronous tile output buses into the clk domain, picks one of
// them (manually or by round-robin auto-scan), registers it onto data_out,
// keeps a snapshot on request and measures edge frequency on bit FBIT of the
// selected bus.
// Ports:
//   clk, rst    : system clock, asynchronous active-high reset
//   ch_data     : flattened tile buses, channel i at [i*W +: W]
//   mode        : 0 = manual select via sel, 1 = auto-scan
//   sel         : manual channel index (out-of-range values are ignored)
//   trig        : snapshot request, also starts a measurement when idle
//   data_out    : registered selected channel
//   cur_ch      : channel currently selected
//   snap_data   : data_out captured at trig
//   snap_ch     : cur_ch captured at trig
//   busy        : measurement window open
//   freq_count  : last completed edge count
//   freq_valid  : pulse when freq_count updates
//   freq_err    : pulse when a measurement is aborted
// -----------------------------------------------------------------------------
module microtile_scan_monitor
    import microtile_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int W           = 8,
    parameter int SELW        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DWELL       = 16,
    parameter int GATE        = 64,
    parameter int FBIT        = 0,
    parameter int CW          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH*W-1:0] ch_data,
    input  logic             mode,
    input  logic [SELW-1:0]  sel,
    input  logic             trig,
    output logic [W-1:0]     data_out,
    output logic [SELW-1:0]  cur_ch,
    output logic [W-1:0]     snap_data,
    output logic [SELW-1:0]  snap_ch,
    output logic             busy,
    output logic [CW-1:0]    freq_count,
    output logic             freq_valid,
    output logic             freq_err
);

    localparam int DWW = width_for(DWELL - 1);
    localparam int SW1 = SELW + 1;
    localparam logic [DWW-1:0]  DWELL_LAST = DWW'(DWELL - 1);
    localparam logic [DWW-1:0]  DWELL_ONE  = DWW'(1);
    localparam logic [SELW-1:0] LAST_CH    = SELW'(NCH - 1);
    localparam logic [SELW-1:0] CH_ONE     = SELW'(1);
    localparam logic [SW1-1:0]  NCH_V      = SW1'(NCH);

    logic [W-1:0]    syn [NCH];
    logic [W-1:0]    sel_bus;
    logic [DWW-1:0]  dwell;
    logic            mode_prev;
    logic            sel_valid;
    logic            sel_moves;
    logic            abort;

    // Plain flop chain per channel; every bit of a bus is sampled
    // independently, so multi-bit values may tear for one cycle on change.
    for (genvar i = 0; i < NCH; i++) begin : g_sync
        logic [W-1:0] pipe [SYNC_STAGES];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s < SYNC_STAGES; s++) pipe[s] <= '0;
            end else begin
                pipe[0] <= ch_data[i*W +: W];
                for (int s = 1; s < SYNC_STAGES; s++) pipe[s] <= pipe[s-1];
            end
        end

        assign syn[i] = pipe[SYNC_STAGES-1];
    end

    // Channel mux written as a compare chain so cur_ch never indexes past
    // the last real channel when NCH is not a power of two.
    always_comb begin
        sel_bus = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cur_ch == SELW'(i)) sel_bus = syn[i];
        end
    end

    // A measurement is only meaningful on one channel in one mode, so any
    // request that would move cur_ch or flip the mode kills it.
    always_comb begin
        sel_valid = ({1'b0, sel} < NCH_V);
        sel_moves = !mode && sel_valid && (sel != cur_ch);
        abort     = busy && (sel_moves || (mode != mode_prev));
    end

    // Channel selection. Entering auto mode restarts the dwell from the
    // channel already selected; the dwell stops while a window is open so
    // the scan cannot move the measured channel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_ch    <= '0;
            dwell     <= '0;
            mode_prev <= 1'b0;
        end else begin
            mode_prev <= mode;
            if (!mode) begin
                if (sel_valid) cur_ch <= sel;
            end else if (!mode_prev) begin
                dwell <= '0;
            end else if (!busy) begin
                if (dwell == DWELL_LAST) begin
                    dwell  <= '0;
                    cur_ch <= (cur_ch == LAST_CH) ? '0 : cur_ch + CH_ONE;
                end else begin
                    dwell <= dwell + DWELL_ONE;
                end
            end
        end
    end

    // Output register and snapshot; the snapshot is taken on every trig,
    // whether or not a measurement is already running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out  <= '0;
            snap_data <= '0;
            snap_ch   <= '0;
        end else begin
            data_out <= sel_bus;
            if (trig) begin
                snap_data <= data_out;
                snap_ch   <= cur_ch;
            end
        end
    end

    microtile_edge_counter #(
        .GATE (GATE),
        .CW   (CW)
    ) u_edge_counter (
        .clk        (clk),
        .rst        (rst),
        .start      (trig),
        .abort      (abort),
        .sample     (data_out[FBIT]),
        .busy       (busy),
        .freq_count (freq_count),
        .freq_valid (freq_valid),
        .freq_err   (freq_err)
    );

endmodule

// File: tb/tb_microtile_scan_monitor.sv
// -----------------------------------------------------------------------------
// tb_microtile_scan_monitor
// Main instance (default parameters) is checked every cycle against a
// reference model that describes behaviour in terms of delays and windows
// over recorded history. A second instance (NCH=3, CW=4) covers out-of-range
// select and counter saturation with fixed expected values.
// -----------------------------------------------------------------------------
module tb_microtile_scan_monitor;

    localparam int NCH   = 4;
    localparam int W     = 8;
    localparam int SELW  = 2;
    localparam int SS    = 2;
    localparam int DWELL = 16;
    localparam int GATE  = 64;
    localparam int FBIT  = 0;
    localparam int CW    = 16;
    localparam int HMAX  = 8192;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH*W-1:0] ch_data;
    logic             mode;
    logic [SELW-1:0]  sel;
    logic             trig;
    logic [W-1:0]     data_out;
    logic [SELW-1:0]  cur_ch;
    logic [W-1:0]     snap_data;
    logic [SELW-1:0]  snap_ch;
    logic             busy;
    logic [CW-1:0]    freq_count;
    logic             freq_valid;
    logic             freq_err;

    logic [3*W-1:0]   b_ch_data;
    logic             b_mode;
    logic [1:0]       b_sel;
    logic             b_trig;
    logic [W-1:0]     b_data_out;
    logic [1:0]       b_cur_ch;
    logic [W-1:0]     b_snap_data;
    logic [1:0]       b_snap_ch;
    logic             b_busy;
    logic [3:0]       b_freq_count;
    logic             b_freq_valid;
    logic             b_freq_err;

    microtile_scan_monitor dut (
        .clk(clk), .rst(rst), .ch_data(ch_data), .mode(mode), .sel(sel),
        .trig(trig), .data_out(data_out), .cur_ch(cur_ch),
        .snap_data(snap_data), .snap_ch(snap_ch), .busy(busy),
        .freq_count(freq_count), .freq_valid(freq_valid), .freq_err(freq_err)
    );

    microtile_scan_monitor #(.NCH(3), .CW(4)) dut_b (
        .clk(clk), .rst(rst), .ch_data(b_ch_data), .mode(b_mode), .sel(b_sel),
        .trig(b_trig), .data_out(b_data_out), .cur_ch(b_cur_ch),
        .snap_data(b_snap_data), .snap_ch(b_snap_ch), .busy(b_busy),
        .freq_count(b_freq_count), .freq_valid(b_freq_valid),
        .freq_err(b_freq_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: input history plus the currently open window.
    logic [NCH*W-1:0] chd_hist [HMAX];
    logic             dbit_hist [HMAX];
    int               edge_n;
    int               m_cur;
    int               m_dwell;
    logic             m_mode_prev;
    logic             m_busy;
    int               m_start;
    logic [W-1:0]     m_dout;
    logic [W-1:0]     m_snap_d;
    int               m_snap_c;
    logic [CW-1:0]    m_fc;
    logic             m_valid;
    logic             m_err;

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        edge_n      = 0;
        m_cur       = 0;
        m_dwell     = 0;
        m_mode_prev = 1'b0;
        m_busy      = 1'b0;
        m_start     = 0;
        m_dout      = '0;
        m_snap_d    = '0;
        m_snap_c    = 0;
        m_fc        = '0;
        m_valid     = 1'b0;
        m_err       = 1'b0;
        dbit_hist[0] = 1'b0;
    endtask

    // One clock edge of the intended behaviour, using the inputs as they
    // were presented at that edge.
    task automatic modelStep();
        int k;
        int new_cur;
        int rises;
        logic [W-1:0] new_dout;
        edge_n++;
        k = edge_n;
        if (k >= HMAX) begin
            $display("[TB] FAIL model_history: edge %0d exceeds %0d", k, HMAX);
            $fatal(1, "[TB] history overflow");
        end
        chd_hist[k] = ch_data;
        // the channel picked before this edge, seen SS edges late
        new_dout = (k - SS >= 1) ? chd_hist[k-SS][m_cur*W +: W] : '0;
        new_cur = m_cur;
        if (!mode) begin
            if (int'(sel) < NCH) new_cur = int'(sel);
        end else if (!m_mode_prev) begin
            m_dwell = 0;
        end else if (!m_busy) begin
            m_dwell++;
            if (m_dwell == DWELL) begin
                m_dwell = 0;
                new_cur = (m_cur + 1) % NCH;
            end
        end
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (m_busy) begin
            if ((mode != m_mode_prev) ||
                (!mode && int'(sel) < NCH && int'(sel) != m_cur)) begin
                m_busy = 1'b0;
                m_err  = 1'b1;
            end else if (k == m_start + GATE) begin
                rises = 0;
                for (int j = m_start; j < m_start + GATE; j++) begin
                    if (dbit_hist[j] && !dbit_hist[j-1]) rises++;
                end
                m_fc    = (rises > (1 << CW) - 1) ? '1 : CW'(rises);
                m_valid = 1'b1;
                m_busy  = 1'b0;
            end
        end else if (trig) begin
            m_busy  = 1'b1;
            m_start = k;
        end
        if (trig) begin
            m_snap_d = m_dout;
            m_snap_c = m_cur;
        end
        m_dout       = new_dout;
        dbit_hist[k] = new_dout[FBIT];
        m_cur        = new_cur;
        m_mode_prev  = mode;
    endtask

    task automatic compareAll();
        checkOutput("data_out",   data_out,   m_dout);
        checkOutput("cur_ch",     cur_ch,     m_cur);
        checkOutput("snap_data",  snap_data,  m_snap_d);
        checkOutput("snap_ch",    snap_ch,    m_snap_c);
        checkOutput("busy",       busy,       m_busy);
        checkOutput("freq_count", freq_count, m_fc);
        checkOutput("freq_valid", freq_valid, m_valid);
        checkOutput("freq_err",   freq_err,   m_err);
    endtask

    task automatic applyStimulus(input logic [NCH*W-1:0] c, input logic [SELW-1:0] s,
                                 input logic md, input logic tg);
        ch_data = c;
        sel     = s;
        mode    = md;
        trig    = tg;
        @(posedge clk);
        modelStep();
        #1;
        compareAll();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_data_out"}, data_out, 0);
        checkOutput({tag, "_cur_ch"}, cur_ch, 0);
        checkOutput({tag, "_snap_data"}, snap_data, 0);
        checkOutput({tag, "_snap_ch"}, snap_ch, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_freq_count"}, freq_count, 0);
        checkOutput({tag, "_freq_valid"}, freq_valid, 0);
        checkOutput({tag, "_freq_err"}, freq_err, 0);
    endtask

    function automatic logic [NCH*W-1:0] toggleBus(input int ph);
        logic [NCH*W-1:0] c;
        c = '0;
        c[1*W + 0] = ((ph % 4) < 2);
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [NCH*W-1:0] cd;
        logic [NCH*W-1:0] r_cd;
        logic [SELW-1:0]  r_sel;
        logic             r_mode;
        logic             seen;
        int               ph;
        int               c0;

        rst = 1'b0; ch_data = '0; mode = 1'b0; sel = '0; trig = 1'b0;
        b_ch_data = '0; b_mode = 1'b0; b_sel = '0; b_trig = 1'b0;
        ph = 0;
        #2 rst = 1'b1;
        #1;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        modelReset();

        // manual select: ch2 carries A5, then 5A
        cd = '0;
        cd[2*W +: W] = 8'hA5;
        repeat (4) applyStimulus(cd, 2'd0, 1'b0, 1'b0);
        applyStimulus(cd, 2'd2, 1'b0, 1'b0);
        checkOutput("man_cur", cur_ch, 2);
        applyStimulus(cd, 2'd2, 1'b0, 1'b0);
        checkOutput("man_data", data_out, 8'hA5);
        cd[2*W +: W] = 8'h5A;
        applyStimulus(cd, 2'd2, 1'b0, 1'b0);
        applyStimulus(cd, 2'd2, 1'b0, 1'b0);
        checkOutput("man_old", data_out, 8'hA5);
        applyStimulus(cd, 2'd2, 1'b0, 1'b0);
        checkOutput("man_new", data_out, 8'h5A);

        // auto-scan round the four channels
        cd = {8'h13, 8'h12, 8'h11, 8'h10};
        repeat (4) applyStimulus(cd, 2'd0, 1'b0, 1'b0);
        checkOutput("scan_pre", data_out, 8'h10);
        applyStimulus(cd, 2'd0, 1'b1, 1'b0);
        for (int j = 1; j <= 4; j++) begin
            repeat (15) applyStimulus(cd, 2'd0, 1'b1, 1'b0);
            checkOutput("scan_hold", cur_ch, (j - 1) % 4);
            applyStimulus(cd, 2'd0, 1'b1, 1'b0);
            checkOutput("scan_step", cur_ch, j % 4);
        end
        applyStimulus(cd, 2'd0, 1'b1, 1'b0);
        checkOutput("scan_data", data_out, 8'h10);

        // dwell frozen while a window is open
        applyStimulus(cd, 2'd0, 1'b1, 1'b1);
        c0 = int'(cur_ch);
        repeat (40) applyStimulus(cd, 2'd0, 1'b1, 1'b0);
        checkOutput("scan_freeze", cur_ch, c0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            applyStimulus(cd, 2'd0, 1'b1, 1'b0);
            seen = freq_valid;
        end
        checkOutput("scan_meas_done", seen, 1);

        // frequency: ch1 bit0 period 4 -> 16 rising edges in 64 cycles
        for (int i = 0; i < 8; i++) begin
            applyStimulus(toggleBus(ph), 2'd1, 1'b0, 1'b0);
            ph++;
        end
        applyStimulus(toggleBus(ph), 2'd1, 1'b0, 1'b1);
        ph++;
        checkOutput("freq_busy_start", busy, 1);
        for (int i = 1; i <= GATE; i++) begin
            applyStimulus(toggleBus(ph), 2'd1, 1'b0, 1'b0);
            ph++;
            if (i < GATE) begin
                checkOutput("freq_busy", busy, 1);
            end else begin
                checkOutput("freq_valid_end", freq_valid, 1);
                checkOutput("freq_count_end", freq_count, 16);
                checkOutput("freq_busy_end", busy, 0);
            end
        end
        applyStimulus(toggleBus(ph), 2'd1, 1'b0, 1'b0);
        ph++;
        checkOutput("freq_valid_once", freq_valid, 0);

        // abort: sel 1 -> 3 ten cycles into the window
        applyStimulus(toggleBus(ph), 2'd1, 1'b0, 1'b1);
        ph++;
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(toggleBus(ph), (i == 10) ? 2'd3 : 2'd1, 1'b0, 1'b0);
            ph++;
        end
        checkOutput("abort_err", freq_err, 1);
        checkOutput("abort_valid", freq_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_count", freq_count, 16);
        applyStimulus(toggleBus(ph), 2'd3, 1'b0, 1'b0);
        ph++;
        checkOutput("abort_err_once", freq_err, 0);

        // reset in the middle of a window
        repeat (4) begin
            applyStimulus(toggleBus(ph), 2'd1, 1'b0, 1'b0);
            ph++;
        end
        applyStimulus(toggleBus(ph), 2'd1, 1'b0, 1'b1);
        ph++;
        repeat (7) begin
            applyStimulus(toggleBus(ph), 2'd1, 1'b0, 1'b0);
            ph++;
        end
        rst = 1'b1;
        #1;
        checkAllZero("rstmid");
        @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
        seen = 1'b0;
        repeat (80) begin
            applyStimulus(toggleBus(ph), 2'd1, 1'b0, 1'b0);
            ph++;
            seen = seen | freq_valid | freq_err;
        end
        checkOutput("rstmid_no_pulse", seen, 0);

        // randomized traffic
        r_cd = '0; r_sel = '0; r_mode = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) r_mode = ~r_mode;
            if ($urandom_range(0, 29) == 0) r_sel = SELW'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) r_cd = $urandom;
            applyStimulus(r_cd, r_sel, r_mode, ($urandom_range(0, 39) == 0));
        end

        // NCH=3, CW=4 instance: sel=3 ignored, saturation at 15
        b_sel = 2'd0;
        repeat (6) begin
            b_ch_data[0] = ~b_ch_data[0];
            @(posedge clk); #1;
        end
        b_sel = 2'd3;
        repeat (3) begin
            b_ch_data[0] = ~b_ch_data[0];
            @(posedge clk); #1;
        end
        checkOutput("b_oor_hold", b_cur_ch, 0);
        b_trig = 1'b1;
        b_ch_data[0] = ~b_ch_data[0];
        @(posedge clk); #1;
        b_trig = 1'b0;
        checkOutput("b_busy", b_busy, 1);
        seen = 1'b0;
        for (int i = 1; i <= GATE; i++) begin
            b_ch_data[0] = ~b_ch_data[0];
            @(posedge clk); #1;
            seen = seen | b_freq_err;
            if (i == GATE) begin
                checkOutput("b_sat_valid", b_freq_valid, 1);
                checkOutput("b_sat_count", b_freq_count, 15);
            end
        end
        checkOutput("b_no_abort", seen, 0);
        checkOutput("b_cur_final", b_cur_ch, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
